cmd_aggregator: RTL and testbench

Assembles three consecutive bytes from the UART receiver into one 24-bit command word and presents it to the command dispatcher with a `cmd_rdy`/`clr_cmd_rdy` handshake. Sits between the UART receiver and the command dispatcher. Owns the inter-byte timeout, so a partial frame cannot stall the command path. Detects command overrun when the dispatcher has not consumed the previous word.

---
 rtl/cmd_aggregator_pkg.sv | 14 +
 rtl/cmd_aggregator_if.sv | 25 ++
 rtl/cmd_aggregator_byte_timer.sv | 30 +++
 rtl/cmd_aggregator.sv | 98 +++++++++
 tb/tb_cmd_aggregator.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/cmd_aggregator_pkg.sv
// Shared definitions for the UART-to-dispatcher command path: frame size
// and the assembly FSM state encoding.
package cmd_aggregator_pkg;

  localparam int CMD_BYTES = 3;
  localparam int CMD_W     = 8 * CMD_BYTES;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } AggState;

endpackage

// File: rtl/cmd_aggregator_if.sv
// Byte stream from the UART receiver in, assembled command word and status
// pulses out towards the command dispatcher.
interface cmd_aggregator_if;
  import cmd_aggregator_pkg::*;

  logic [7:0]       rx_data;
  logic             rx_rdy;
  logic             clr_rx_rdy;
  logic [CMD_W-1:0] cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             overrun;
  logic             frame_err;

  modport slave (
    input  rx_data, rx_rdy, clr_cmd_rdy,
    output clr_rx_rdy, cmd, cmd_rdy, overrun, frame_err
  );

  modport master (
    output rx_data, rx_rdy, clr_cmd_rdy,
    input  clr_rx_rdy, cmd, cmd_rdy, overrun, frame_err
  );

endinterface

// File: rtl/cmd_aggregator_byte_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// flags the final cycle of the TO_CYCLES window.
module byte_timer #(
  parameter int TO_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TO_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/cmd_aggregator.sv
// Collects three UART bytes into a 24-bit command word, hands it to the
// dispatcher, and reports overruns and timed-out partial frames.
module cmd_aggregator
  import cmd_aggregator_pkg::*;
#(
  parameter int TO_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  cmd_aggregator_if.slave   bus
);

  localparam logic [1:0] ST_WAIT_B0 = WAIT_B0;
  localparam logic [1:0] ST_WAIT_B1 = WAIT_B1;
  localparam logic [1:0] ST_WAIT_B2 = WAIT_B2;

  logic [1:0]       state;
  logic [15:0]      asm_reg;
  logic [CMD_W-1:0] cmd_reg;
  logic             cmd_rdy_reg;
  logic             overrun_reg;
  logic             frame_err_reg;

  logic accept;
  logic complete;
  logic timer_en;
  logic timer_clr;
  logic expired;

  assign accept   = bus.rx_rdy;
  assign complete = accept && (state == ST_WAIT_B2);
  assign timer_en = (state != ST_WAIT_B0);
  // Counter restarts on every byte and after a timeout so it never wraps.
  assign timer_clr = accept || !timer_en || expired;

  byte_timer #(
    .TO_CYCLES (TO_CYCLES)
  ) u_byte_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_WAIT_B0;
      asm_reg       <= '0;
      cmd_reg       <= '0;
      cmd_rdy_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      if (bus.clr_cmd_rdy) begin
        cmd_rdy_reg <= 1'b0;
      end
      if (accept) begin
        case (state)
          ST_WAIT_B0: begin
            asm_reg[15:8] <= bus.rx_data;
            state         <= ST_WAIT_B1;
          end
          ST_WAIT_B1: begin
            asm_reg[7:0] <= bus.rx_data;
            state        <= ST_WAIT_B2;
          end
          default: begin
            state <= ST_WAIT_B0;
            // A consume in the completing cycle frees the output register.
            if (!cmd_rdy_reg || bus.clr_cmd_rdy) begin
              cmd_reg     <= {asm_reg, bus.rx_data};
              cmd_rdy_reg <= 1'b1;
            end else begin
              overrun_reg <= 1'b1;
            end
          end
        endcase
      end else if (expired) begin
        state         <= ST_WAIT_B0;
        asm_reg       <= '0;
        frame_err_reg <= 1'b1;
      end
    end
  end

  assign bus.clr_rx_rdy = bus.rx_rdy & rst_n;
  assign bus.cmd        = cmd_reg;
  assign bus.cmd_rdy    = cmd_rdy_reg;
  assign bus.overrun    = overrun_reg;
  assign bus.frame_err  = frame_err_reg;

  logic unused_complete;
  assign unused_complete = complete;

endmodule

// File: tb/tb_cmd_aggregator.sv
// Directed bench for cmd_aggregator with a 16-cycle inter-byte timeout.
module tb_cmd_aggregator;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  cmd_aggregator_if bus ();

  cmd_aggregator #(.TO_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte for a single accepted cycle, optionally with a consume strobe.
  task automatic send(input logic [7:0] b, input logic c);
    bus.rx_data     = b;
    bus.rx_rdy      = 1'b1;
    bus.clr_cmd_rdy = c;
    #1;
    chk("clr_rx_rdy_hi", {31'd0, bus.clr_rx_rdy}, 32'd1);
    @(posedge clk);
    #1;
    bus.rx_rdy      = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    #1;
    chk("clr_rx_rdy_lo", {31'd0, bus.clr_rx_rdy}, 32'd0);
  endtask

  task automatic consume();
    bus.clr_cmd_rdy = 1'b1;
    step(1);
    bus.clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.rx_data     = 8'h00;
    bus.rx_rdy      = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    step(2);
    chk("rst_clr_rx_rdy", {31'd0, bus.clr_rx_rdy}, 32'd0);
    chk("rst_cmd",        {8'd0, bus.cmd}, 32'h0);
    chk("rst_cmd_rdy",    {31'd0, bus.cmd_rdy}, 32'd0);
    chk("rst_overrun",    {31'd0, bus.overrun}, 32'd0);
    chk("rst_frame_err",  {31'd0, bus.frame_err}, 32'd0);
    bus.rx_rdy = 1'b0;
    rst_n      = 1'b1;
    step(1);

    // Basic frame, bytes spaced ten cycles apart
    send(8'h02, 1'b0);
    chk("t1_rdy_b0", {31'd0, bus.cmd_rdy}, 32'd0);
    step(9);
    send(8'h1C, 1'b0);
    chk("t1_rdy_b1", {31'd0, bus.cmd_rdy}, 32'd0);
    step(9);
    send(8'h00, 1'b0);
    chk("t1_cmd", {8'd0, bus.cmd}, 32'h021C00);
    chk("t1_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    chk("t1_frame_err", {31'd0, bus.frame_err}, 32'd0);

    // Overrun: previous word still pending
    send(8'h08, 1'b0);
    send(8'h03, 1'b0);
    send(8'hAA, 1'b0);
    chk("t2_overrun", {31'd0, bus.overrun}, 32'd1);
    chk("t2_cmd_kept", {8'd0, bus.cmd}, 32'h021C00);
    chk("t2_rdy_kept", {31'd0, bus.cmd_rdy}, 32'd1);
    step(1);
    chk("t2_overrun_end", {31'd0, bus.overrun}, 32'd0);
    consume();
    chk("t2_rdy_clr", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("t2_cmd_after_clr", {8'd0, bus.cmd}, 32'h021C00);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("t2_next_cmd", {8'd0, bus.cmd}, 32'h112233);
    chk("t2_next_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    chk("t2_next_overrun", {31'd0, bus.overrun}, 32'd0);

    // Consume strobe in the same cycle as byte2
    send(8'h03, 1'b0);
    send(8'h00, 1'b0);
    send(8'h80, 1'b1);
    chk("t4_cmd", {8'd0, bus.cmd}, 32'h030080);
    chk("t4_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    chk("t4_overrun", {31'd0, bus.overrun}, 32'd0);
    consume();
    chk("t4_rdy_clr", {31'd0, bus.cmd_rdy}, 32'd0);

    // Timeout on a lone byte
    send(8'h09, 1'b0);
    step(TO - 1);
    chk("t3_no_err_early", {31'd0, bus.frame_err}, 32'd0);
    step(1);
    chk("t3_frame_err", {31'd0, bus.frame_err}, 32'd1);
    chk("t3_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("t3_cmd_kept", {8'd0, bus.cmd}, 32'h030080);
    step(1);
    chk("t3_frame_err_end", {31'd0, bus.frame_err}, 32'd0);
    send(8'h09, 1'b0);
    send(8'h05, 1'b0);
    send(8'h00, 1'b0);
    chk("t3_cmd", {8'd0, bus.cmd}, 32'h090500);
    chk("t3_rdy_set", {31'd0, bus.cmd_rdy}, 32'd1);
    consume();

    // Byte arriving exactly on the timeout cycle wins
    send(8'h0A, 1'b0);
    step(TO - 1);
    send(8'h0B, 1'b0);
    chk("t6_no_err", {31'd0, bus.frame_err}, 32'd0);
    send(8'h0C, 1'b0);
    chk("t6_no_err2", {31'd0, bus.frame_err}, 32'd0);
    chk("t6_cmd", {8'd0, bus.cmd}, 32'h0A0B0C);
    chk("t6_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    step(TO + 2);
    chk("t6_idle_no_err", {31'd0, bus.frame_err}, 32'd0);

    // Reset mid-frame with a word still pending
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_cmd_rst", {8'd0, bus.cmd}, 32'h0);
    chk("t5_rdy_rst", {31'd0, bus.cmd_rdy}, 32'd0);
    chk("t5_overrun_rst", {31'd0, bus.overrun}, 32'd0);
    chk("t5_frame_err_rst", {31'd0, bus.frame_err}, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    chk("t5_rdy_mid", {31'd0, bus.cmd_rdy}, 32'd0);
    send(8'h01, 1'b0);
    chk("t5_cmd", {8'd0, bus.cmd}, 32'h020001);
    chk("t5_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    chk("t5_overrun", {31'd0, bus.overrun}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
